// File: rtl/title_blitter.sv
// Purpose: per-frame word copier. It copies from SRC_BASE to DST_BASE with an
//          optional blink XOR, and it services frame and key interrupts.
// Latency: 3 cycles per word, so a ready frame takes 3*FRAME_LEN + 3 cycles from INT_IACK to INT_IEND.
// Backpressure: none inside a frame; GPU_READY low at the check skips the whole frame.
module title_blitter #(
  parameter int              DW           = 16,
  parameter int              AW           = 16,
  parameter logic [AW-1:0]   SRC_BASE     = AW'(16'h0800),
  parameter logic [AW-1:0]   DST_BASE     = AW'(16'hA000),
  parameter int              FRAME_LEN    = 1280,
  parameter int              BLINK_PERIOD = 0,
  parameter logic [DW-1:0]   BLINK_MASK   = '1,
  parameter logic [7:0]      START_KEY    = 8'h5A,
  parameter logic [7:0]      ABORT_KEY    = 8'h20
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          ENABLE,
  output logic          SWITCH_REQUEST,
  output logic          FATAL_ERROR,
  output logic          MEM_ENABLE,
  output logic          MEM_WRITE,
  output logic [AW-1:0] MEM_ADDR,
  input  logic [DW-1:0] MEM_DATA_R,
  output logic [DW-1:0] MEM_DATA_W,
  input  logic          GPU_READY,
  output logic          GPU_DRAW,
  input  logic [7:0]    KBD_KEY,
  input  logic [1:0]    INT_IRQ,
  output logic          INT_IACK,
  output logic          INT_IEND
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_WAIT, ST_FACK, ST_GCHK, ST_RD, ST_LAT,
    ST_WR, ST_DRAW, ST_FEND, ST_KACK, ST_KEND, ST_HALT
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] idx;
  logic [31:0]   frame_cnt;
  logic [31:0]   frame_inc;
  logic          phase;
  logic [7:0]    key_buf;
  logic [DW-1:0] data_buf;
  logic          idx_last;
  logic          key_abort;
  logic          key_start;

  assign frame_inc = frame_cnt + 32'd1;
  assign idx_last  = (idx == LAST_IDX);
  // Abort wins when both key parameters are the same code.
  assign key_abort = (key_buf == ABORT_KEY);
  assign key_start = (key_buf == START_KEY) && !key_abort;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Dropping ENABLE sends every state except HALT to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        case (INT_IRQ)
          2'b00:   state_nxt = ST_FACK;
          2'b01:   state_nxt = ST_KACK;
          default: state_nxt = ST_WAIT;
        endcase
      end
      ST_FACK: state_nxt = ST_GCHK;
      ST_GCHK: state_nxt = GPU_READY ? ST_RD : ST_FEND;
      ST_RD:   state_nxt = ST_LAT;
      ST_LAT:  state_nxt = ST_WR;
      ST_WR:   state_nxt = idx_last ? ST_DRAW : ST_RD;
      ST_DRAW: state_nxt = ST_FEND;
      ST_FEND: state_nxt = ST_WAIT;
      ST_KACK: state_nxt = ST_KEND;
      ST_KEND: state_nxt = key_abort ? ST_HALT : ST_WAIT;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
    if (!ENABLE && state != ST_HALT) begin
      state_nxt = ST_IDLE;
    end
  end

  // Datapath. Word index, frame and blink counters, data buffer and key buffer.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      idx       <= '0;
      frame_cnt <= '0;
      phase     <= 1'b0;
      key_buf   <= '0;
      data_buf  <= '0;
    end else begin
      case (state)
        ST_IDLE: idx <= '0;
        ST_FACK: begin
          if (BLINK_PERIOD != 0 && frame_inc == 32'(BLINK_PERIOD)) begin
            frame_cnt <= '0;
            phase     <= ~phase;
          end else begin
            frame_cnt <= frame_inc;
          end
        end
        ST_LAT:  data_buf <= MEM_DATA_R;
        ST_WR:   idx <= idx_last ? '0 : idx + AW'(1);
        ST_KACK: key_buf <= KBD_KEY;
        default: ;
      endcase
    end
  end

  // Output decode from the registered state. RESET masks it so that a reset
  // landing on a write cycle drives no strobe.
  always_comb begin
    MEM_ENABLE     = 1'b0;
    MEM_WRITE      = 1'b0;
    MEM_ADDR       = '0;
    MEM_DATA_W     = '0;
    GPU_DRAW       = 1'b0;
    INT_IACK       = 1'b0;
    INT_IEND       = 1'b0;
    SWITCH_REQUEST = 1'b0;
    FATAL_ERROR    = 1'b0;
    case (state)
      ST_FACK: INT_IACK = 1'b1;
      ST_RD: begin
        MEM_ENABLE = 1'b1;
        MEM_ADDR   = SRC_BASE + idx;
      end
      ST_WR: begin
        MEM_ENABLE = 1'b1;
        MEM_WRITE  = 1'b1;
        MEM_ADDR   = DST_BASE + idx;
        MEM_DATA_W = data_buf ^ (phase ? BLINK_MASK : '0);
      end
      ST_DRAW: GPU_DRAW = 1'b1;
      ST_FEND: INT_IEND = 1'b1;
      ST_KACK: INT_IACK = 1'b1;
      ST_KEND: begin
        INT_IEND       = 1'b1;
        SWITCH_REQUEST = key_start;
      end
      ST_HALT: FATAL_ERROR = 1'b1;
      default: ;
    endcase
    if (RESET) begin
      MEM_ENABLE     = 1'b0;
      MEM_WRITE      = 1'b0;
      MEM_ADDR       = '0;
      MEM_DATA_W     = '0;
      GPU_DRAW       = 1'b0;
      INT_IACK       = 1'b0;
      INT_IEND       = 1'b0;
      SWITCH_REQUEST = 1'b0;
      FATAL_ERROR    = 1'b0;
    end
  end

endmodule

// File: tb/tb_title_blitter.sv
// Purpose: randomized self-checking bench for title_blitter with a frame-level reference model.
// Latency: the model expects 3*FL+3 cycles from IACK to IEND for a ready frame and 2 cycles for a skipped frame.
// Backpressure: the bench drives GPU_READY randomly for each frame.
module tb_title_blitter;

  localparam int          FL   = 4;
  localparam logic [15:0] SRC  = 16'hFFFE;
  localparam logic [15:0] DST  = 16'hA000;
  localparam int          BP   = 2;
  localparam logic [15:0] MASK = 16'hFFFF;
  localparam logic [7:0]  KST  = 8'h5A;
  localparam logic [7:0]  KAB  = 8'h20;

  logic        CLK = 1'b0;
  logic        RESET, ENABLE, GPU_READY;
  logic        SWITCH_REQUEST, FATAL_ERROR, MEM_ENABLE, MEM_WRITE, GPU_DRAW, INT_IACK, INT_IEND;
  logic [15:0] MEM_ADDR, MEM_DATA_W;
  logic [15:0] MEM_DATA_R = 16'h0;
  logic [7:0]  KBD_KEY;
  logic [1:0]  INT_IRQ;

  title_blitter #(
    .DW(16), .AW(16), .SRC_BASE(SRC), .DST_BASE(DST), .FRAME_LEN(FL),
    .BLINK_PERIOD(BP), .BLINK_MASK(MASK), .START_KEY(KST), .ABORT_KEY(KAB)
  ) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
    .SWITCH_REQUEST(SWITCH_REQUEST), .FATAL_ERROR(FATAL_ERROR),
    .MEM_ENABLE(MEM_ENABLE), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
    .MEM_DATA_R(MEM_DATA_R), .MEM_DATA_W(MEM_DATA_W),
    .GPU_READY(GPU_READY), .GPU_DRAW(GPU_DRAW),
    .KBD_KEY(KBD_KEY), .INT_IRQ(INT_IRQ), .INT_IACK(INT_IACK), .INT_IEND(INT_IEND)
  );

  always #5 CLK = ~CLK;

  // Source words held by the bench; any other address returns a marker value.
  logic [15:0] src_w [FL];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          model_frames = 0;

  // Synchronous memory with one cycle of read latency.
  always @(posedge CLK) begin
    if (MEM_ENABLE && !MEM_WRITE) begin
      if (16'(MEM_ADDR - SRC) < 16'(FL)) MEM_DATA_R <= src_w[16'(MEM_ADDR - SRC)];
      else                               MEM_DATA_R <= 16'hDEAD;
    end
  end

  // Bus monitor. It samples on the falling edge.
  logic [15:0] rd_q [$];
  logic [15:0] wa_q [$];
  logic [15:0] wd_q [$];
  int cyc = 0, n_draw = 0, n_iack = 0, n_iend = 0, n_sw = 0, iack_cyc = 0, iend_cyc = 0;
  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (MEM_ENABLE && !MEM_WRITE) rd_q.push_back(MEM_ADDR);
    if (MEM_ENABLE && MEM_WRITE) begin
      wa_q.push_back(MEM_ADDR);
      wd_q.push_back(MEM_DATA_W);
    end
    if (GPU_DRAW) n_draw = n_draw + 1;
    if (INT_IACK) begin n_iack = n_iack + 1; iack_cyc = cyc; end
    if (INT_IEND) begin n_iend = n_iend + 1; iend_cyc = cyc; end
    if (SWITCH_REQUEST) n_sw = n_sw + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic clear_log();
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    n_draw = 0; n_iack = 0; n_iend = 0; n_sw = 0;
  endtask

  task automatic wait_iack();
    for (int i = 0; i < 20 && n_iack == 0; i++) tick(1);
    chk("iack_seen", 32'(n_iack != 0), 32'd1);
  endtask

  task automatic wait_iend();
    for (int i = 0; i < 100 && n_iend == 0; i++) tick(1);
    chk("iend_seen", 32'(n_iend != 0), 32'd1);
  endtask

  task automatic wait_rd(input int n);
    for (int i = 0; i < 40 && rd_q.size() < n; i++) tick(1);
    chk("rd_reached", 32'(rd_q.size()), 32'(n));
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick(2);
    chk("rst_mem_en", 32'(MEM_ENABLE), 0);
    chk("rst_mem_wr", 32'(MEM_WRITE), 0);
    chk("rst_addr", 32'(MEM_ADDR), 0);
    chk("rst_wdata", 32'(MEM_DATA_W), 0);
    chk("rst_strobes", 32'({GPU_DRAW, INT_IACK, INT_IEND, SWITCH_REQUEST, FATAL_ERROR}), 0);
    RESET = 1'b0;
    model_frames = 0;
    tick(1);
    chk("post_rst_quiet", 32'({MEM_ENABLE, GPU_DRAW, INT_IACK, INT_IEND, FATAL_ERROR}), 0);
  endtask

  // Model: frame k after reset (counting from 1) has blink phase (k / BP) mod 2.
  task automatic do_frame(input bit rdy);
    logic ph;
    clear_log();
    GPU_READY = rdy;
    INT_IRQ = 2'b00;
    wait_iack();
    INT_IRQ = 2'b10;
    model_frames = model_frames + 1;
    ph = ((model_frames / BP) % 2) == 1;
    wait_iend();
    tick(2);
    chk("iack_cnt", 32'(n_iack), 32'd1);
    chk("iend_dist", 32'(iend_cyc - iack_cyc), rdy ? 32'(3 * FL + 3) : 32'd2);
    chk("draw_cnt", 32'(n_draw), 32'(rdy));
    chk("rd_cnt", 32'(rd_q.size()), rdy ? 32'(FL) : 32'd0);
    chk("wr_cnt", 32'(wa_q.size()), rdy ? 32'(FL) : 32'd0);
    for (int i = 0; i < FL; i++) begin
      if (i < rd_q.size()) chk("rd_addr", 32'(rd_q[i]), 32'(16'(SRC + 16'(i))));
      if (i < wa_q.size()) begin
        chk("wr_addr", 32'(wa_q[i]), 32'(16'(DST + 16'(i))));
        chk("wr_data", 32'(wd_q[i]), 32'(src_w[i] ^ (ph ? MASK : 16'h0)));
      end
    end
  endtask

  task automatic do_key(input logic [7:0] k);
    clear_log();
    KBD_KEY = k;
    INT_IRQ = 2'b01;
    wait_iack();
    INT_IRQ = 2'b10;
    wait_iend();
    tick(2);
    chk("key_iend_dist", 32'(iend_cyc - iack_cyc), 32'd1);
    chk("key_switch", 32'(n_sw), 32'(k == KST && k != KAB));
    chk("key_fatal", 32'(FATAL_ERROR), 32'(k == KAB));
    chk("key_no_mem", 32'(rd_q.size() + wa_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] k;
    RESET = 1'b1; ENABLE = 1'b1; GPU_READY = 1'b0; KBD_KEY = 8'h00; INT_IRQ = 2'b10;
    for (int i = 0; i < FL; i++) src_w[i] = 16'(i + 1);
    do_reset();

    // Directed: words 1..4 across the address wrap, then one skipped frame.
    do_frame(1'b1);
    do_frame(1'b0);

    // Blink sequence on constant data.
    do_reset();
    for (int i = 0; i < FL; i++) src_w[i] = 16'h00F0;
    for (int f = 0; f < 4; f++) do_frame(1'b1);

    // Random frames.
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < FL; i++) src_w[i] = 16'($urandom);
      do_frame(1'($urandom_range(0, 3) != 0));
    end

    // ENABLE dropped while the third word is being read.
    clear_log();
    GPU_READY = 1'b1;
    INT_IRQ = 2'b00;
    wait_iack();
    INT_IRQ = 2'b10;
    model_frames = model_frames + 1;
    wait_rd(3);
    ENABLE = 1'b0;
    tick(10);
    chk("abort_rd_cnt", 32'(rd_q.size()), 32'd3);
    chk("abort_wr_cnt", 32'(wa_q.size()), 32'd2);
    chk("abort_draw", 32'(n_draw), 32'd0);
    chk("abort_iend", 32'(n_iend), 32'd0);
    ENABLE = 1'b1;
    tick(2);
    do_frame(1'b1);

    // RESET raised during a write cycle.
    clear_log();
    INT_IRQ = 2'b00;
    wait_iack();
    INT_IRQ = 2'b10;
    wait_rd(2);
    @(posedge CLK);
    @(posedge CLK);
    #1 RESET = 1'b1;
    tick(1);
    chk("rst_wr_suppressed", 32'(MEM_ENABLE), 32'd0);
    chk("rst_wr_cnt", 32'(wa_q.size()), 32'd1);
    tick(1);
    RESET = 1'b0;
    model_frames = 0;
    tick(20);
    chk("rst_no_draw", 32'(n_draw), 32'd0);
    chk("rst_no_iend", 32'(n_iend), 32'd0);
    chk("rst_wr_cnt_after", 32'(wa_q.size()), 32'd1);
    do_frame(1'b1);

    // Keys: random ordinary codes, then the start key, then the abort key.
    for (int i = 0; i < 4; i++) begin
      k = 8'($urandom_range(0, 255));
      if (k == KST || k == KAB) k = 8'h11;
      do_key(k);
    end
    do_key(KST);
    do_key(KAB);
    clear_log();
    INT_IRQ = 2'b00;
    tick(20);
    chk("halt_no_iack", 32'(n_iack), 32'd0);
    chk("halt_fatal", 32'(FATAL_ERROR), 32'd1);
    ENABLE = 1'b0;
    tick(5);
    chk("halt_fatal_disabled", 32'(FATAL_ERROR), 32'd1);
    ENABLE = 1'b1;
    INT_IRQ = 2'b10;
    do_reset();
    chk("fatal_cleared", 32'(FATAL_ERROR), 32'd0);
    do_frame(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
